// File: rtl/hack_dmem_responder.sv
// hack_dmem_responder
//   Data-memory responder for the Hack CPU. Serves one read port and one
//   write port on a map of block RAM plus memory-mapped I/O:
//     0x0000..RAM_DEPTH-1  RAM (read/write)
//     0x4000               LED register (read/write)
//     0x4001               synchronised buttons (read-only)
//     0x4002               UART transmit data (write-only, reads 0)
//     0x4003               UART status {overflow, busy} (any write clears overflow)
//   Read data is registered: inM shows the value at addressMR one clock later.
//   A read and a write to the same location in one cycle return the old value.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   addressMR  read address
//   addressMW  write address
//   outM       write data
//   writeM     write strobe, commits on the rising edge
//   inM        registered read data
//   btn        raw asynchronous buttons, active-high
//   led        LED register
//   uart_tx    serial output, idle high, 8N1, LSB first
module hack_dmem_responder #(
  parameter int RAM_DEPTH    = 4096,
  parameter int CLKS_PER_BIT = 104,
  parameter int NBTN         = 4,
  parameter int NLED         = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      addressMR,
  input  logic [15:0]      addressMW,
  input  logic [15:0]      outM,
  input  logic             writeM,
  output logic [15:0]      inM,
  input  logic [NBTN-1:0]  btn,
  output logic [NLED-1:0]  led,
  output logic             uart_tx
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [16:0]   RAM_END   = 17'(RAM_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [15:0] A_LED  = 16'h4000;
  localparam logic [15:0] A_BTN  = 16'h4001;
  localparam logic [15:0] A_DATA = 16'h4002;
  localparam logic [15:0] A_STAT = 16'h4003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // Write decode
  logic wr_ram;
  logic wr_uart;
  logic wr_stat;
  logic wr_led;

  assign wr_ram  = writeM && ({1'b0, addressMW} < RAM_END);
  assign wr_led  = writeM && (addressMW == A_LED);
  assign wr_uart = writeM && (addressMW == A_DATA);
  assign wr_stat = writeM && (addressMW == A_STAT);

  // RAM: no reset so it maps onto block RAM. The read and write sit in the
  // same process so the read naturally returns the pre-write contents.
  logic [15:0] mem [RAM_DEPTH];
  logic [15:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (wr_ram) mem[addressMW[AW-1:0]] <= outM;
    ram_rd_q <= mem[addressMR[AW-1:0]];
  end

  // Control and I/O registers
  uart_state_t     state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [NLED-1:0] led_q, led_d;
  logic [NBTN-1:0] btn_s1_q, btn_s2_q;
  logic            sel_ram_q, sel_ram_d;
  logic [15:0]     io_rd_q, io_rd_d;
  logic            busy;

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      led_q     <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      sel_ram_q <= 1'b0;
      io_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      led_q     <= led_d;
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      sel_ram_q <= sel_ram_d;
      io_rd_q   <= io_rd_d;
    end
  end

  // LED and overflow flag. Set is evaluated last so it wins over a clear.
  always_comb begin
    led_d = led_q;
    if (wr_led) led_d = outM[NLED-1:0];

    ovf_d = ovf_q;
    if (wr_stat)         ovf_d = 1'b0;
    if (wr_uart && busy) ovf_d = 1'b1;
  end

  // UART transmitter
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    case (state_q)
      S_IDLE: begin
        if (wr_uart) begin
          shift_d = outM[7:0];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is derived from the next state so the output is a flop
    // that lines up exactly with the state register.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Read mux. RAM data and I/O data are registered separately and selected
  // after the flops, which keeps the RAM read port free of reset logic while
  // still forcing inM to zero during reset.
  always_comb begin
    sel_ram_d = ({1'b0, addressMR} < RAM_END);
    case (addressMR)
      A_LED:   io_rd_d = 16'(led_q);
      A_BTN:   io_rd_d = 16'(btn_s2_q);
      A_STAT:  io_rd_d = {14'd0, ovf_q, busy};
      default: io_rd_d = '0;
    endcase
  end

  assign inM     = sel_ram_q ? ram_rd_q : io_rd_q;
  assign led     = led_q;
  assign uart_tx = tx_q;

endmodule

// File: tb/tb_hack_dmem_responder.sv
module tb_hack_dmem_responder;

  localparam int RD = 4096;
  localparam int C  = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] addressMR, addressMW, outM;
  logic        writeM;
  logic [15:0] inM;
  logic [3:0]  btn;
  logic [7:0]  led;
  logic        uart_tx;

  int n_cmp = 0;
  int n_bad = 0;

  hack_dmem_responder #(
    .RAM_DEPTH(RD), .CLKS_PER_BIT(C), .NBTN(4), .NLED(8)
  ) dut (
    .clk(clk), .rstn(rstn), .addressMR(addressMR), .addressMW(addressMW),
    .outM(outM), .writeM(writeM), .inM(inM), .btn(btn), .led(led),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Reference model: memory map as plain arrays, UART as "frame started at
  // edge e0, lasts 10*C edges", bit value taken from the frame layout.
  logic [15:0] m_ram [int];
  logic [7:0]  m_led;
  logic        m_ovf;
  logic [3:0]  m_s1, m_s2;
  bit          m_act;
  int          m_e0;
  logic [7:0]  m_byte;
  int          m_n = 0;

  task automatic m_reset();
    m_led = '0; m_ovf = 1'b0; m_s1 = '0; m_s2 = '0; m_act = 0;
  endtask

  function automatic bit m_busy(input int k);
    return m_act && (k >= m_e0) && (k < m_e0 + 10 * C);
  endfunction

  function automatic logic m_tx_at(input int k);
    int idx;
    if (!m_busy(k)) return 1'b1;
    idx = (k - m_e0) / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  task automatic m_read(input logic [15:0] a, output logic [15:0] ex, output bit ok);
    ok = 1; ex = '0;
    if (int'(a) < RD) begin
      if (m_ram.exists(int'(a))) ex = m_ram[int'(a)];
      else ok = 0;
    end else if (a == 16'h4000) ex = {8'd0, m_led};
    else if (a == 16'h4001) ex = {12'd0, m_s2};
    else if (a == 16'h4003) ex = {14'd0, m_ovf, m_busy(m_n)};
  endtask

  task automatic m_edge(input logic w, input logic [15:0] aw, input logic [15:0] d);
    bit busy_pre;
    busy_pre = m_busy(m_n);
    if (w) begin
      if (int'(aw) < RD) m_ram[int'(aw)] = d;
      else if (aw == 16'h4000) m_led = d[7:0];
      else if (aw == 16'h4002) begin
        if (busy_pre) m_ovf = 1'b1;
        else begin
          m_act = 1; m_e0 = m_n + 1; m_byte = d[7:0];
        end
      end else if (aw == 16'h4003) m_ovf = 1'b0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
    m_n++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, compare against the model.
  task automatic cyc(input logic w, input logic [15:0] aw, input logic [15:0] d,
                     input logic [15:0] ar);
    logic [15:0] ex;
    bit ok;
    writeM = w; addressMW = aw; outM = d; addressMR = ar;
    m_read(ar, ex, ok);
    @(posedge clk);
    #1;
    m_edge(w, aw, d);
    if (ok) check("model_inM", inM, ex);
    check("model_led", {8'd0, led}, {8'd0, m_led});
    check("model_tx", {15'd0, uart_tx}, {15'd0, m_tx_at(m_n)});
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 16'($urandom_range(0, 63));
      4:          return 16'h4000 + 16'($urandom_range(0, 4));
      5:          return 16'h4003;
      6:          return 16'(RD - 1);
      7:          return 16'(RD);
      8:          return 16'h4002;
      default:    return 16'($urandom);
    endcase
  endfunction

  initial begin
    rstn = 1'b0; writeM = 1'b0; addressMR = '0; addressMW = '0; outM = '0; btn = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_inM", inM, 16'h0000);
    check("rst_led", {8'd0, led}, 16'h0000);
    check("rst_tx", {15'd0, uart_tx}, 16'h0001);
    rstn = 1'b1;

    // Give the RAM region under test known contents.
    for (int a = 0; a < 64; a++) cyc(1'b1, 16'(a), 16'h0000, 16'h4003);
    cyc(1'b1, 16'(RD - 1), 16'h7FFF, 16'h4003);

    // RAM write then read
    cyc(1'b1, 16'h0005, 16'hBEEF, 16'h4003);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0005);
    check("ram_read", inM, 16'hBEEF);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0006);
    check("ram_unwritten", inM, 16'h0000);
    cyc(1'b0, 16'h0000, 16'h0000, 16'(RD - 1));
    check("ram_top", inM, 16'h7FFF);
    cyc(1'b1, 16'(RD), 16'h1234, 16'(RD));
    check("above_ram", inM, 16'h0000);

    // Read-first collision
    cyc(1'b1, 16'h0010, 16'h1111, 16'h0000);
    cyc(1'b1, 16'h0010, 16'h2222, 16'h0010);
    check("collide_old", inM, 16'h1111);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0010);
    check("collide_new", inM, 16'h2222);

    // LED / BTN
    cyc(1'b1, 16'h4000, 16'h00A5, 16'h0000);
    check("led_reg", {8'd0, led}, 16'h00A5);
    cyc(1'b1, 16'h4001, 16'hFFFF, 16'h4000);
    check("led_read", inM, 16'h00A5);
    btn = 4'b1010;
    repeat (3) cyc(1'b0, 16'h0000, 16'h0000, 16'h4001);
    check("btn_sync", inM, 16'h000A);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h4002);
    check("uart_data_read", inM, 16'h0000);

    // UART frame
    cyc(1'b1, 16'h4002, 16'h0055, 16'h4003);
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
      check("stat_busy", inM, 16'h0001);
    end
    cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
    check("stat_idle", inM, 16'h0000);

    // Overflow
    cyc(1'b1, 16'h4002, 16'h00C3, 16'h4003);
    repeat (10) cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
    cyc(1'b1, 16'h4002, 16'h00FF, 16'h4003);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
    check("stat_ovf", inM, 16'h0003);
    cyc(1'b1, 16'h4003, 16'h0000, 16'h4003);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
    check("stat_ovf_clr", inM, 16'h0001);
    repeat (30) cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
    check("stat_done", inM, 16'h0000);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) btn = 4'($urandom);
      cyc(1'($urandom_range(0, 1)), pick_addr(), 16'($urandom), pick_addr());
    end
    repeat (45) cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);

    // Asynchronous reset in the middle of a frame
    cyc(1'b1, 16'h4000, 16'h005A, 16'h0000);
    cyc(1'b1, 16'h0020, 16'hCAFE, 16'h0000);
    cyc(1'b1, 16'h4002, 16'h0000, 16'h0020);
    repeat (8) cyc(1'b0, 16'h0000, 16'h0000, 16'h0020);
    check("pre_rst_tx", {15'd0, uart_tx}, 16'h0000);
    check("pre_rst_inM", inM, 16'hCAFE);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_tx", {15'd0, uart_tx}, 16'h0001);
    check("arst_led", {8'd0, led}, 16'h0000);
    check("arst_inM", inM, 16'h0000);
    rstn = 1'b1;
    m_reset();
    cyc(1'b0, 16'h0000, 16'h0000, 16'h4003);
    check("post_rst_stat", inM, 16'h0000);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0020);
    check("post_rst_ram", inM, 16'hCAFE);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h4000);
    check("post_rst_led", inM, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_dmem_responder.md
Name: hack_dmem_responder

Overview:
- Data-memory responder on the Hack CPU's data bus: serves reads on the read-address port and writes on the write-address/data/strobe port.
- Decodes a memory map of block RAM plus memory-mapped I/O: LED register, synchronised buttons, and a UART transmitter with status.
- Sits between the CPU's outM/writeM/addressMR/addressMW outputs and its inM input.
- Read data is registered: the value for addressMR is valid one clock after the address is presented, which the CPU's FETCH-phase M capture tolerates.

Parameters:
- RAM_DEPTH, 4096, number of 16-bit RAM words; must be a power of two, at most 4096. Maps to 0x0000..RAM_DEPTH-1.
- CLKS_PER_BIT, 104, clock cycles per UART bit; must be at least 2.
- NBTN, 4, number of button inputs.
- NLED, 8, number of LED outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- addressMR  in  16  read address.
- addressMW  in  16  write address.
- outM  in  16  write data.
- writeM  in  1  write strobe; a write commits on the rising edge where writeM=1.
- inM  out  16  registered read data.
- btn  in  NBTN  raw asynchronous buttons, active-high.
- led  out  NLED  LED register.
- uart_tx  out  1  serial output, idle high, 8N1, LSB first.

Behaviour:
- Reset (rstn low, asynchronous): inM=0, led=0, uart_tx=1, UART FSM=IDLE, overflow flag=0, button synchroniser=0. RAM contents are not reset. Reset mid-frame aborts the frame immediately and uart_tx goes high.
- Memory map, decoded on the full 16 bits:
  - 0x0000..RAM_DEPTH-1: RAM, read/write.
  - 0x4000 LED: read/write. Write takes outM[NLED-1:0]; read zero-extends.
  - 0x4001 BTN: read-only. Reads the two-flop synchronised btn, zero-extended; writes are ignored.
  - 0x4002 UART_DATA: write-only; reads return 0. A write while IDLE latches outM[7:0] and starts a frame. A write while busy is dropped and sets the overflow flag.
  - 0x4003 UART_STAT: bit0=busy (FSM not IDLE), bit1=overflow (sticky), other bits 0. Any write clears overflow. If a clearing write and an overflowing write coincide in the same cycle, set wins.
  - Any other address: reads return 0, writes are ignored.
- Read path: inM <= mux(addressMR) on every rising edge. Latency is one clock; there is no enable and no stall.
- Read and write to the same address in the same cycle: read-first, i.e. inM gets the pre-write value. The new value is visible on the next cycle's read.
- addressMR and addressMW are independent; a read and a write to different locations proceed in the same cycle.
- UART FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: uart_tx=1. A write to UART_DATA loads the shift register and clears the baud counter; the next state is START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. A 3-bit bit index wraps from 7 to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - A full frame is exactly 10*CLKS_PER_BIT cycles.
  - busy reads 1 on the cycle after the accepting write. A write landing on the cycle STOP returns to IDLE is dropped (busy is still 1); software must poll until busy=0.
- Baud counter width: clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.

Test Plan:
- RAM write/read: writeM=1, addressMW=0x0005, outM=0xBEEF; next cycle addressMR=0x0005 -> inM=0xBEEF one clock later. addressMR=0x0006 (never written, preloaded 0) -> inM=0x0000.
- Read-first collision: preload RAM[0x10]=0x1111; same cycle write 0x2222 to 0x10 with addressMR=0x10 -> inM=0x1111. Next cycle -> inM=0x2222.
- LED/BTN: write 0x00A5 to 0x4000 -> led=0xA5; read 0x4000 -> inM=0x00A5. Drive btn=4'b1010 -> inM at 0x4001 is 0x000A no later than 3 clocks after the change.
- UART frame (CLKS_PER_BIT=4): write 0x0055 to 0x4002 -> uart_tx is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1. STAT reads 0x0001 during the frame and 0x0000 after 40 cycles.
- Overflow: a second write to 0x4002 mid-frame -> frame bits unchanged, STAT=0x0003. A write to 0x4003 -> STAT=0x0001.
- Async reset mid-frame: deassert rstn during DATA -> uart_tx=1, led=0, inM=0 immediately without a clock edge. After release, STAT=0x0000 and RAM keeps prior contents.
